// File: rtl/ddr_axi_read_checker.sv
// AXI4 read-back checker: walks a DDR region one INCR burst at a time and compares
// every returned beat against the writer's regenerated LFSR pattern.

module ddr_axi_read_checker_lane (
  input  logic [31:0] i_data,
  input  logic [31:0] i_exp,
  output logic        o_mismatch
);
  assign o_mismatch = (i_data != i_exp);
endmodule

module ddr_axi_read_checker #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    BURST_LEN  = 16,
  parameter int                    NUM_BURSTS = 256,
  parameter logic [31:0]           SEED       = 32'h0000_0001
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [31:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int                    LANES       = DATA_WIDTH / 32;
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES  = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
  localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [31:0]           LAST_BURST  = 32'(NUM_BURSTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_busy, r_done, r_pass, r_arvalid, r_rready;
  logic [31:0]           r_err_count, r_lfsr, r_burst_cnt;
  logic [ADDR_WIDTH-1:0] r_first_err_addr, r_araddr;
  logic [7:0]            r_beat_cnt;

  logic [LANES-1:0]      w_lane_mis;
  logic                  w_start, w_ar_hs, w_beat, w_last, w_final, w_bad;
  logic [31:0]           w_lfsr_nxt;
  logic [ADDR_WIDTH-1:0] w_beat_addr;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ddr_axi_read_checker_lane u_lane (
      .i_data     (m_axi_rdata[g*32 +: 32]),
      .i_exp      (r_lfsr),
      .o_mismatch (w_lane_mis[g])
    );
  end

  assign w_start     = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_ar_hs     = (r_state == S_ADDR) && r_arvalid && m_axi_arready;
  assign w_beat      = (r_state == S_DATA) && r_rready && m_axi_rvalid;
  // End of burst is decided by our own counter; rlast is only checked against it.
  assign w_last      = (r_beat_cnt == LAST_BEAT);
  assign w_final     = (r_burst_cnt == LAST_BURST);
  assign w_bad       = (|w_lane_mis) || (m_axi_rresp != 2'b00) || (m_axi_rlast != w_last);
  assign w_lfsr_nxt  = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
  assign w_beat_addr = r_araddr + ADDR_WIDTH'(r_beat_cnt) * BEAT_BYTES;

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start)          w_state_nxt = S_ADDR;
      S_ADDR:         if (w_ar_hs)        w_state_nxt = S_DATA;
      S_DATA:         if (w_beat && w_last) w_state_nxt = w_final ? S_DONE : S_ADDR;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_arvalid        <= 1'b0;
      r_rready         <= 1'b0;
      r_araddr         <= BASE_ADDR;
      r_lfsr           <= SEED;
      r_burst_cnt      <= '0;
      r_beat_cnt       <= '0;
    end else begin
      if (w_start) begin
        r_busy           <= 1'b1;
        r_done           <= 1'b0;
        r_pass           <= 1'b0;
        r_err_count      <= '0;
        r_first_err_addr <= '0;
        r_lfsr           <= SEED;
        r_araddr         <= BASE_ADDR;
        r_burst_cnt      <= '0;
        r_beat_cnt       <= '0;
        r_arvalid        <= 1'b1;
      end
      if (w_ar_hs) begin
        r_arvalid  <= 1'b0;
        r_rready   <= 1'b1;
        r_beat_cnt <= '0;
      end
      if (w_beat) begin
        r_lfsr     <= w_lfsr_nxt;
        r_beat_cnt <= r_beat_cnt + 8'd1;
        if (w_bad) begin
          if (r_err_count != '1) r_err_count <= r_err_count + 32'd1;
          if (r_err_count == '0) r_first_err_addr <= w_beat_addr;
        end
        if (w_last) begin
          r_rready    <= 1'b0;
          r_beat_cnt  <= '0;
          r_burst_cnt <= r_burst_cnt + 32'd1;
          r_araddr    <= r_araddr + BURST_BYTES;
          if (w_final) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_pass <= !w_bad && (r_err_count == '0);
          end else begin
            r_arvalid <= 1'b1;
          end
        end
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;
  assign m_axi_araddr   = r_araddr;
  assign m_axi_arlen    = LAST_BEAT;
  assign m_axi_arsize   = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arvalid  = r_arvalid;
  assign m_axi_rready   = r_rready;
endmodule

// File: tb/tb_ddr_axi_read_checker.sv
// Directed bench for ddr_axi_read_checker: 2 bursts x 4 beats against a preloaded
// memory model with injectable data/resp/rlast faults and optional stalls.

module tb_ddr_axi_read_checker;
  logic         aclk = 1'b0;
  logic         areset, start;
  logic         busy, done, pass;
  logic [31:0]  err_count;
  logic [63:0]  first_err_addr, m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst, m_axi_rresp;
  logic         m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [127:0] m_axi_rdata;

  always #5 aclk = ~aclk;

  ddr_axi_read_checker #(
    .ADDR_WIDTH(64), .DATA_WIDTH(128), .BASE_ADDR(64'h0),
    .BURST_LEN(4), .NUM_BURSTS(2), .SEED(32'h1)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // Writer pattern for SEED=1, hand-stepped through the LFSR
  logic [31:0] pat [0:7] = '{32'h1, 32'h3, 32'h6, 32'hD, 32'h1B, 32'h36, 32'h6D, 32'hDB};

  int          corrupt_idx = -1, resp_idx = -1, early_idx = -1;
  bit          stall = 1'b0;
  int          stab_err = 0;
  logic [63:0] ar_log [$];
  int          nassert = 0, nfail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge aclk); start = 1'b1;
    @(negedge aclk); start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge aclk);
      n++;
    end
    check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  // AXI slave memory model; decisions are made on the falling edge
  initial begin
    bit          s_busy, s_armed, ar_pend, r_pend;
    int          s_beat, dly, g;
    logic [63:0] s_addr, ar_addr_p, s_hold;
    s_busy = 0; s_armed = 0; ar_pend = 0; r_pend = 0;
    s_beat = 0; dly = 0; g = 0; s_addr = 0; ar_addr_p = 0; s_hold = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0; m_axi_rlast = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
        s_busy = 0; s_armed = 0; ar_pend = 0; r_pend = 0;
      end else begin
        if (ar_pend) begin
          s_busy = 1; s_addr = ar_addr_p; s_beat = 0; s_armed = 0;
          m_axi_arready = 0;
          ar_log.push_back(ar_addr_p);
        end
        if (r_pend) begin
          s_beat++;
          m_axi_rvalid = 0; m_axi_rlast = 0;
          if (s_beat == 4) s_busy = 0;
        end
        if (m_axi_arvalid && !m_axi_arready) begin
          if (!s_armed) begin
            s_armed = 1; s_hold = m_axi_araddr;
            dly = stall ? int'($urandom_range(0, 5)) : 0;
          end else if (m_axi_araddr !== s_hold) stab_err++;
          if (dly == 0) m_axi_arready = 1;
          else dly--;
        end
        if (s_busy && !m_axi_rvalid && !(stall && $urandom_range(0, 2) == 0)) begin
          g = (int'(s_addr >> 4) + s_beat) & 7;
          m_axi_rdata = {4{pat[g]}};
          if (g == corrupt_idx) m_axi_rdata[0] = ~m_axi_rdata[0];
          m_axi_rresp  = (g == resp_idx) ? 2'b10 : 2'b00;
          m_axi_rlast  = (s_beat == 3) || (g == early_idx);
          m_axi_rvalid = 1;
        end
        ar_pend   = m_axi_arvalid && m_axi_arready;
        ar_addr_p = m_axi_araddr;
        r_pend    = m_axi_rvalid && m_axi_rready;
      end
    end
  end

  initial begin
    areset = 1'b1; start = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_busy",    {63'd0, busy}, 64'd0);
    check("rst_done",    {63'd0, done}, 64'd0);
    check("rst_pass",    {63'd0, pass}, 64'd0);
    check("rst_err",     {32'd0, err_count}, 64'd0);
    check("rst_first",   first_err_addr, 64'd0);
    check("rst_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
    check("rst_rready",  {63'd0, m_axi_rready}, 64'd0);
    check("rst_araddr",  m_axi_araddr, 64'd0);
    check("arlen",       {56'd0, m_axi_arlen}, 64'd3);
    check("arsize",      {61'd0, m_axi_arsize}, 64'd4);
    check("arburst",     {62'd0, m_axi_arburst}, 64'd1);
    areset = 1'b0;

    // Clean pass
    ar_log.delete();
    start_pulse();
    check("ar_latency",  {63'd0, m_axi_arvalid}, 64'd1);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_done();
    check("clean_pass",  {63'd0, pass}, 64'd1);
    check("clean_err",   {32'd0, err_count}, 64'd0);
    check("clean_first", first_err_addr, 64'd0);
    check("clean_busy",  {63'd0, busy}, 64'd0);
    check("clean_nar",   64'(ar_log.size()), 64'd2);
    check("clean_ar0",   ar_log[0], 64'h0);
    check("clean_ar1",   ar_log[1], 64'h40);

    // Burst 1 beat 2 corrupted; start issued from DONE
    corrupt_idx = 6; ar_log.delete();
    start_pulse();
    check("done_drop",   {63'd0, done}, 64'd0);
    wait_done();
    check("corr_pass",   {63'd0, pass}, 64'd0);
    check("corr_err",    {32'd0, err_count}, 64'd1);
    check("corr_first",  first_err_addr, 64'h60);
    corrupt_idx = -1;

    // RRESP error on beat at 0x10 plus early rlast at 0x50
    resp_idx = 1; early_idx = 5;
    start_pulse();
    wait_done();
    check("resp_pass",   {63'd0, pass}, 64'd0);
    check("resp_err",    {32'd0, err_count}, 64'd2);
    check("resp_first",  first_err_addr, 64'h10);
    resp_idx = -1; early_idx = -1;

    // Random arready delays and rvalid gaps
    stall = 1'b1; stab_err = 0; ar_log.delete();
    start_pulse();
    wait_done();
    check("stall_pass",  {63'd0, pass}, 64'd1);
    check("stall_err",   {32'd0, err_count}, 64'd0);
    check("stall_nar",   64'(ar_log.size()), 64'd2);
    check("stall_ar0",   ar_log[0], 64'h0);
    check("stall_ar1",   ar_log[1], 64'h40);
    check("stall_stable", 64'(stab_err), 64'd0);
    stall = 1'b0;

    // Reset in the middle of a burst, with a start coincident with reset
    start_pulse();
    repeat (2) @(negedge aclk);
    check("mid_in_data", {63'd0, m_axi_rready}, 64'd1);
    areset = 1'b1;
    @(negedge aclk);
    check("mrst_busy",    {63'd0, busy}, 64'd0);
    check("mrst_done",    {63'd0, done}, 64'd0);
    check("mrst_pass",    {63'd0, pass}, 64'd0);
    check("mrst_err",     {32'd0, err_count}, 64'd0);
    check("mrst_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
    check("mrst_rready",  {63'd0, m_axi_rready}, 64'd0);
    check("mrst_araddr",  m_axi_araddr, 64'd0);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0; areset = 1'b0;
    @(negedge aclk);
    check("rst_start_ignored", {63'd0, busy}, 64'd0);
    check("rst_start_noar",    {63'd0, m_axi_arvalid}, 64'd0);
    ar_log.delete();
    start_pulse();
    wait_done();
    check("post_rst_pass", {63'd0, pass}, 64'd1);
    check("post_rst_ar0",  ar_log[0], 64'h0);

    // Start while busy is ignored; start in DONE restarts and clears counts
    corrupt_idx = 2; ar_log.delete();
    start_pulse();
    repeat (3) @(negedge aclk);
    start_pulse();
    wait_done();
    check("busy_start_nar", 64'(ar_log.size()), 64'd2);
    check("busy_start_err", {32'd0, err_count}, 64'd1);
    check("busy_start_first", first_err_addr, 64'h20);
    corrupt_idx = -1;
    start_pulse();
    check("restart_done", {63'd0, done}, 64'd0);
    check("restart_err",  {32'd0, err_count}, 64'd0);
    check("restart_busy", {63'd0, busy}, 64'd1);
    wait_done();
    check("restart_pass", {63'd0, pass}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/ddr_axi_read_checker.md
Name: ddr_axi_read_checker

Overview:
- PL-side AXI4 read master that reads back a DDR4 region previously filled by the PL traffic writer.
- Connects through a NoC slave port to the DDR4 DIMM1 memory controller.
- Regenerates the writer's LFSR data pattern beat by beat, compares each returned beat against it, and reports pass/fail, error count and first failing address to the debug/status logic.
- Issues exactly one burst at a time (single outstanding AR).

Parameters:
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 128, AXI data width; must be a multiple of 32.
- BASE_ADDR, 64'h0000_0000_0000_0000, start address of the checked region; must be aligned to DATA_WIDTH/8.
- BURST_LEN, 16, beats per burst, range 1..256.
- NUM_BURSTS, 256, bursts per check pass, must be ≥ 1.
- SEED, 32'h0000_0001, LFSR seed; must be nonzero and identical to the writer's seed.

Ports:
- aclk, input, 1, single clock for all logic.
- areset, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse that begins a check pass; ignored unless in IDLE or DONE.
- busy, output, 1, high from the cycle after an accepted start until DONE is entered.
- done, output, 1, high while in DONE.
- pass, output, 1, valid while done is high; 1 = no errors.
- err_count, output, 32, mismatching beats plus RRESP errors; saturates at 32'hFFFF_FFFF.
- first_err_addr, output, ADDR_WIDTH, address of the first failing beat; 0 if none.
- m_axi_araddr, output, ADDR_WIDTH, read burst address.
- m_axi_arlen, output, 8, BURST_LEN-1.
- m_axi_arsize, output, 3, log2(DATA_WIDTH/8).
- m_axi_arburst, output, 2, constant 2'b01 (INCR).
- m_axi_arvalid, output, 1, read address valid.
- m_axi_arready, input, 1, read address ready.
- m_axi_rdata, input, DATA_WIDTH, read data.
- m_axi_rresp, input, 2, read response.
- m_axi_rlast, input, 1, last beat of burst.
- m_axi_rvalid, input, 1, read data valid.
- m_axi_rready, output, 1, read data ready.

Behaviour:
- Reset values (on areset): state=IDLE; busy=0; done=0; pass=0; err_count=0; first_err_addr=0; arvalid=0; rready=0; araddr=BASE_ADDR; lfsr=SEED; burst and beat counters 0.
- Reset mid-burst: abandons the transaction immediately with no drain; the outstanding R data is the interconnect's responsibility.
- LFSR step: next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}. Advances exactly once per accepted R beat.
- Expected beat: DATA_WIDTH/32 copies of the current lfsr value.
- State machine:
  - IDLE: on start, clear err_count, first_err_addr and pass; set lfsr=SEED, araddr=BASE_ADDR, burst_cnt=0, busy=1; go to ADDR.
  - ADDR: arvalid=1. araddr, arlen and arsize hold stable until arvalid && arready. On handshake: arvalid=0 and rready=1 in the next cycle; go to DATA.
  - DATA: a beat is accepted on rvalid && rready.
    - A beat errors if rdata≠expected, rresp≠2'b00, or rlast is wrong. rlast must be 1 exactly when beat_cnt==BURST_LEN-1.
    - An errored beat counts once even if several checks fail.
    - On the first error of the pass, first_err_addr = araddr + beat_cnt*(DATA_WIDTH/8).
    - On the last beat (beat_cnt==BURST_LEN-1, judged by the counter, not rlast): rready=0, burst_cnt++, araddr += BURST_LEN*(DATA_WIDTH/8) (wraps modulo 2^ADDR_WIDTH). Go to ADDR, or to DONE if burst_cnt was NUM_BURSTS-1.
  - DONE: done=1, busy=0, pass=(err_count==0). Outputs hold until areset or start. Start in DONE behaves as start in IDLE; done drops the next cycle.
- Start while busy is ignored. A start coincident with areset is ignored; reset wins.
- Latency:
  - arvalid rises 1 cycle after start is sampled.
  - The result is visible 1 cycle after the final beat handshake.
  - Minimum idle gap between bursts: 1 cycle, ADDR only (no extra bubble).
- Back-pressure: rready stays 1 throughout DATA; rvalid gaps do not advance the LFSR or the beat counter.
- Saturation: once err_count reaches max, further errors do not wrap.

Test Plan:
- SEED=1, BURST_LEN=4, NUM_BURSTS=2, memory model preloaded with the writer pattern, arready/rvalid always high -> first beats carry 32'h00000001, 32'h00000003, 32'h00000006 replicated; done after 2 bursts; pass=1; err_count=0; araddrs 0x0 then 0x40.
- Same setup with beat 2 of burst 1 corrupted (bit 0 flipped) -> pass=0, err_count=1, first_err_addr=0x60.
- rresp=2'b10 on one beat of otherwise correct data, plus one rlast asserted early in another burst -> err_count=2, first_err_addr=address of the first of the two beats.
- Random arready delays of 0-5 cycles and rvalid gaps -> araddr stable while arvalid waits; result identical to the no-stall run.
- areset pulse in DATA mid-burst, then start -> all outputs at reset values the cycle after reset; the second pass completes with pass=1, and its first araddr=BASE_ADDR.
- start pulsed while busy and again in DONE -> the first is ignored (no extra AR); the second restarts with done=0 the next cycle and err_count cleared.
